// File: rtl/instruction_fetch_buffer_if.sv
// Instruction memory read bus: request/ready handshake plus in-order responses.
// The fetch buffer is the master; the instruction memory is the slave.
interface instruction_fetch_buffer_if;
  logic        memRequestValid;
  logic [31:0] memRequestAddress;
  logic        memRequestReady;
  logic        memResponseValid;
  logic [31:0] memResponseData;
  logic        memResponseError;

  modport master (
    output memRequestValid,
    output memRequestAddress,
    input  memRequestReady,
    input  memResponseValid,
    input  memResponseData,
    input  memResponseError
  );

  modport slave (
    input  memRequestValid,
    input  memRequestAddress,
    output memRequestReady,
    output memResponseValid,
    output memResponseData,
    output memResponseError
  );
endinterface

// File: rtl/instruction_fetch_buffer.sv
// Two-entry address-tagged instruction buffer with one in-flight PC+4 prefetch.
// Flags misaligned PCs and bus-error words as instruction faults.
module instruction_fetch_buffer #(
  parameter bit PREFETCH_ENABLE = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instructionAddress,
  input  logic        invalidateBuffer,
  output logic        instructionDataValid,
  output logic [31:0] instructionData,
  output logic        instructionFault,
  instruction_fetch_buffer_if.master mem
);

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       valid_q, valid_d;
  logic [1:0][31:0] addr_q, addr_d;
  logic [1:0][31:0] data_q, data_d;
  logic [1:0]       err_q, err_d;
  logic             ptr_q, ptr_d;
  logic             drop_q, drop_d;
  logic [31:0]      reqAddr_q, reqAddr_d;

  logic        misaligned;
  logic [31:0] pcNext;
  logic [1:0]  hit;
  logic [1:0]  nextHit;
  logic        haveTarget;
  logic [31:0] target;
  logic        victim;

  assign misaligned = |instructionAddress[1:0];
  assign pcNext     = instructionAddress + 32'd4;

  assign hit[0] = valid_q[0] && (addr_q[0] == instructionAddress);
  assign hit[1] = valid_q[1] && (addr_q[1] == instructionAddress);
  assign nextHit[0] = valid_q[0] && (addr_q[0] == pcNext);
  assign nextHit[1] = valid_q[1] && (addr_q[1] == pcNext);

  assign mem.memRequestValid   = (state_q == REQUEST);
  assign mem.memRequestAddress = reqAddr_q;

  // Demand miss first, then the sequential prefetch.
  always_comb begin
    haveTarget = 1'b0;
    target     = instructionAddress;
    if (!misaligned) begin
      if (hit == 2'b00) begin
        haveTarget = 1'b1;
      end else if (PREFETCH_ENABLE && (nextHit == 2'b00)) begin
        haveTarget = 1'b1;
        target     = pcNext;
      end
    end
  end

  always_comb begin
    instructionDataValid = 1'b0;
    instructionData      = '0;
    instructionFault     = 1'b0;
    if (!reset) begin
      instructionDataValid = misaligned | (|hit);
      if (misaligned) begin
        instructionFault = 1'b1;
      end else if (hit[0]) begin
        instructionFault = err_q[0];
        instructionData  = err_q[0] ? '0 : data_q[0];
      end else if (hit[1]) begin
        instructionFault = err_q[1];
        instructionData  = err_q[1] ? '0 : data_q[1];
      end
    end
  end

  // Never overwrite the entry the fetch stage is currently reading.
  always_comb begin
    victim = ptr_q;
    if (hit == 2'b01) begin
      victim = 1'b1;
    end else if (hit == 2'b10) begin
      victim = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    addr_d    = addr_q;
    data_d    = data_q;
    err_d     = err_q;
    ptr_d     = ptr_q;
    drop_d    = drop_q;
    reqAddr_d = reqAddr_q;

    unique case (state_q)
      IDLE: begin
        if (haveTarget) begin
          reqAddr_d = target;
          state_d   = REQUEST;
        end
      end
      REQUEST: begin
        if (invalidateBuffer) begin
          drop_d = 1'b1;
        end
        if (mem.memRequestReady) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem.memResponseValid) begin
          state_d = IDLE;
          drop_d  = 1'b0;
          if (!drop_q && !invalidateBuffer) begin
            valid_d[victim] = 1'b1;
            addr_d[victim]  = reqAddr_q;
            data_d[victim]  = mem.memResponseData;
            err_d[victim]   = mem.memResponseError;
            if (hit[0] == hit[1]) begin
              ptr_d = ~ptr_q;
            end
          end
        end else if (invalidateBuffer) begin
          drop_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (invalidateBuffer) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      err_q     <= '0;
      ptr_q     <= 1'b0;
      drop_q    <= 1'b0;
      reqAddr_q <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      err_q     <= err_d;
      ptr_q     <= ptr_d;
      drop_q    <= drop_d;
      reqAddr_q <= reqAddr_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Bench for instruction_fetch_buffer: directed scenarios plus a randomized run
// against a memory model whose contents change on every invalidate.
module tb_instruction_fetch_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        inval;
  logic        dv;
  logic [31:0] dat;
  logic        flt;

  instruction_fetch_buffer_if bus();

  instruction_fetch_buffer #(
    .PREFETCH_ENABLE(1'b1)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .instructionAddress   (pc),
    .invalidateBuffer     (inval),
    .instructionDataValid (dv),
    .instructionData      (dat),
    .instructionFault     (flt),
    .mem                  (bus)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory image: content depends on address and on the invalidate generation.
  function automatic logic [31:0] memfn(input logic [31:0] a, input int g);
    logic [31:0] gv;
    gv = 32'(g);
    if (a == 32'h0 && g == 0) return 32'h0000_0013;
    return {gv[7:0], a[25:2]};
  endfunction

  function automatic logic errfn(input logic [31:0] a);
    return a[6:2] == 5'h10;
  endfunction

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          due;
  } rsp_t;

  rsp_t        rq[$];
  logic [31:0] reqlog[$];
  int          cyc = 0;
  int          gen = 0;
  int          rdy_mode = 1;
  int          lat_lo = 1;
  int          lat_hi = 1;
  int          last_due = 0;
  bit          inj = 1'b0;
  logic [31:0] inj_d = '0;

  // Memory model: in-order responses, each at least one cycle after acceptance.
  initial begin : memory
    rsp_t r;
    int   due;
    bus.memRequestReady  = 1'b0;
    bus.memResponseValid = 1'b0;
    bus.memResponseData  = '0;
    bus.memResponseError = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      if (inj) begin
        bus.memResponseValid = 1'b1;
        bus.memResponseData  = inj_d;
        bus.memResponseError = 1'b0;
        inj = 1'b0;
      end else if (rq.size() > 0 && rq[0].due <= cyc) begin
        r = rq.pop_front();
        bus.memResponseValid = 1'b1;
        bus.memResponseData  = r.d;
        bus.memResponseError = r.e;
      end else begin
        bus.memResponseValid = 1'b0;
        bus.memResponseData  = '0;
        bus.memResponseError = 1'b0;
      end
      if (rdy_mode == 0) bus.memRequestReady = 1'b0;
      else if (rdy_mode == 1) bus.memRequestReady = 1'b1;
      else bus.memRequestReady = ($urandom_range(0, 3) != 0);
      #1;
      if (reset) begin
        rq.delete();
        last_due = 0;
      end else if (bus.memRequestValid && bus.memRequestReady) begin
        due = cyc + $urandom_range(lat_lo, lat_hi);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        r.d   = memfn(bus.memRequestAddress, gen);
        r.e   = errfn(bus.memRequestAddress);
        r.due = due;
        rq.push_back(r);
        reqlog.push_back(bus.memRequestAddress);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    inval = 1'b0;
    @(negedge clock);
    #2;
  endtask

  task automatic wait_dv(input int bound);
    for (int k = 0; k < bound; k++) begin
      @(negedge clock);
      #2;
      if (dv) break;
    end
  endtask

  int          base;
  bit          adv;
  bit          done;
  int          r;
  int          wait_cnt;
  logic [31:0] prev_pc;
  logic [31:0] prev_rqa;
  logic        prev_dv;
  logic        prev_inval;
  logic        prev_rqv;
  logic        prev_rdy;

  initial begin
    reset = 1'b1;
    inval = 1'b0;
    pc    = 32'h2;
    repeat (2) @(negedge clock);
    #2;
    chk("rst_dv", 32'(dv), 0);
    chk("rst_flt", 32'(flt), 0);
    chk("rst_dat", dat, 0);
    chk("rst_rqv", 32'(bus.memRequestValid), 0);
    chk("rst_rqa", bus.memRequestAddress, 0);

    // Demand miss timing, then sequential run with prefetch.
    pc = 32'h0; rdy_mode = 1; lat_lo = 1; lat_hi = 1;
    base = reqlog.size();
    @(negedge clock); reset = 1'b0; #2;
    chk("t1_c0_dv", 32'(dv), 0);
    chk("t1_c0_rqv", 32'(bus.memRequestValid), 0);
    @(negedge clock); #2;
    chk("t1_c1_rqv", 32'(bus.memRequestValid), 1);
    chk("t1_c1_rqa", bus.memRequestAddress, 32'h0);
    @(negedge clock); #2;
    chk("t1_c2_dv", 32'(dv), 0);
    @(negedge clock); #2;
    chk("t1_c3_dv", 32'(dv), 1);
    chk("t1_c3_dat", dat, 32'h0000_0013);
    @(negedge clock); #2;
    chk("t1_c4_rqv", 32'(bus.memRequestValid), 1);
    chk("t1_c4_rqa", bus.memRequestAddress, 32'h4);

    adv = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 80 && !done; k++) begin
      @(negedge clock);
      if (adv) pc = pc + 32'd4;
      adv = 1'b0;
      #2;
      if (dv) begin
        chk("t2_dat", dat, memfn(pc, gen));
        if (pc == 32'h10) done = 1'b1;
        else adv = 1'b1;
      end
    end
    chk("t2_done", 32'(done), 1);
    chk("t2_nreq", 32'(reqlog.size() - base >= 5), 1);
    for (int i = base + 1; i < reqlog.size(); i++)
      chk("t2_seq", reqlog[i], reqlog[i-1] + 32'd4);

    // Redirect while 0x8 is outstanding.
    do_reset();
    pc = 32'h8; lat_lo = 3; lat_hi = 3; rdy_mode = 1;
    base = reqlog.size();
    @(negedge clock); reset = 1'b0; #2;
    @(negedge clock); #2;
    chk("t3_rqa8", bus.memRequestAddress, 32'h8);
    @(negedge clock); pc = 32'h100; #2;
    chk("t3_dv_redirect", 32'(dv), 0);
    wait_dv(40);
    chk("t3_dv100", 32'(dv), 1);
    chk("t3_dat100", dat, memfn(32'h100, gen));
    chk("t3_nreq", 32'(reqlog.size() - base >= 2), 1);
    if (reqlog.size() >= base + 2)
      chk("t3_req2", reqlog[base+1], 32'h100);
    @(negedge clock); pc = 32'h8; #2;
    chk("t3_stored8", 32'(dv), 1);
    chk("t3_dat8", dat, memfn(32'h8, gen));

    // Held request address, then invalidate while waiting.
    do_reset();
    pc = 32'h20; rdy_mode = 0; lat_lo = 3; lat_hi = 3;
    base = reqlog.size();
    @(negedge clock); reset = 1'b0; #2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock); #2;
      chk("t4_hold_v", 32'(bus.memRequestValid), 1);
      chk("t4_hold_a", bus.memRequestAddress, 32'h20);
    end
    rdy_mode = 1;
    @(negedge clock); #2;
    chk("t4_acc_v", 32'(bus.memRequestValid), 1);
    @(negedge clock); inval = 1'b1; #2;
    gen++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock); inval = 1'b0; #2;
      chk("t4_drop_dv", 32'(dv), 0);
    end
    wait_dv(40);
    chk("t4_dv", 32'(dv), 1);
    chk("t4_dat", dat, memfn(32'h20, gen));
    chk("t4_nreq", 32'(reqlog.size() - base >= 2), 1);
    if (reqlog.size() >= base + 2)
      chk("t4_rereq", reqlog[base+1], 32'h20);

    // Bus error, then misaligned PC.
    do_reset();
    pc = 32'h40; rdy_mode = 1; lat_lo = 1; lat_hi = 2;
    @(negedge clock); reset = 1'b0; #2;
    wait_dv(20);
    chk("t5_dv", 32'(dv), 1);
    chk("t5_flt", 32'(flt), 1);
    chk("t5_dat", dat, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock); #2;
      chk("t5_hold", 32'(dv), 1);
    end
    base = reqlog.size();
    @(negedge clock); pc = 32'h42; #2;
    chk("t5_mis_dv", 32'(dv), 1);
    chk("t5_mis_flt", 32'(flt), 1);
    chk("t5_mis_dat", dat, 0);
    repeat (5) @(negedge clock);
    #2;
    chk("t5_mis_noreq", 32'(reqlog.size()), 32'(base));
    chk("t5_mis_rqv", 32'(bus.memRequestValid), 0);

    // Reset mid-request and a stray response in IDLE.
    do_reset();
    pc = 32'h60; rdy_mode = 0; lat_lo = 1; lat_hi = 1;
    @(negedge clock); reset = 1'b0; #2;
    @(negedge clock); #2;
    chk("t6_rqv", 32'(bus.memRequestValid), 1);
    @(negedge clock); reset = 1'b1; #2;
    chk("t6_rst_rqv", 32'(bus.memRequestValid), 0);
    chk("t6_rst_rqa", bus.memRequestAddress, 0);
    chk("t6_rst_dv", 32'(dv), 0);
    pc = 32'h0;
    inj_d = 32'hDEAD_BEEF;
    inj = 1'b1;
    @(negedge clock); reset = 1'b0; #2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock); #2;
      chk("t6_stray_dv", 32'(dv), 0);
    end
    rdy_mode = 1;
    wait_dv(20);
    chk("t6_dv", 32'(dv), 1);
    chk("t6_dat", dat, memfn(32'h0, gen));

    // Prefetch address wraps past the top of memory.
    do_reset();
    pc = 32'hFFFF_FFFC; rdy_mode = 1; lat_lo = 1; lat_hi = 1;
    @(negedge clock); reset = 1'b0; #2;
    wait_dv(20);
    chk("t7_dat", dat, memfn(32'hFFFF_FFFC, gen));
    @(negedge clock); #2;
    chk("t7_wrap_v", 32'(bus.memRequestValid), 1);
    chk("t7_wrap_a", bus.memRequestAddress, 32'h0);

    // Randomized run.
    do_reset();
    pc = 32'h0; rdy_mode = 2; lat_lo = 1; lat_hi = 4;
    @(negedge clock); reset = 1'b0; #2;
    prev_pc = pc; prev_dv = 1'b0; prev_inval = 1'b0;
    prev_rqv = 1'b0; prev_rdy = 1'b0; prev_rqa = '0;
    wait_cnt = 0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clock);
      inval = ($urandom_range(0, 99) < 3);
      if (prev_dv) begin
        r = $urandom_range(0, 99);
        if (r < 70) pc = (pc & ~32'h3) + 32'd4;
        else if (r < 82) pc = 32'($urandom_range(0, 127)) << 2;
        else if (r < 90) pc = {pc[31:2], 2'($urandom_range(1, 3))};
        else if (r < 95) pc = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
      end else if ($urandom_range(0, 99) < 3) begin
        pc = 32'($urandom_range(0, 127)) << 2;
      end
      #2;
      if (pc[1:0] != 2'b00) begin
        chk("rnd_mis_dv", 32'(dv), 1);
        chk("rnd_mis_flt", 32'(flt), 1);
        chk("rnd_mis_dat", dat, 0);
      end else if (dv) begin
        chk("rnd_flt", 32'(flt), 32'(errfn(pc)));
        chk("rnd_dat", dat, errfn(pc) ? 32'h0 : memfn(pc, gen));
      end
      if (pc == prev_pc && prev_dv && !prev_inval)
        chk("rnd_hold", 32'(dv), 1);
      if (prev_rqv && !prev_rdy) begin
        chk("rnd_rq_keep_v", 32'(bus.memRequestValid), 1);
        chk("rnd_rq_keep_a", bus.memRequestAddress, prev_rqa);
      end
      if (bus.memRequestValid)
        chk("rnd_rq_align", 32'(bus.memRequestAddress[1:0]), 0);
      if (dv || pc != prev_pc) wait_cnt = 0;
      else wait_cnt++;
      if (wait_cnt > 60) begin
        chk("rnd_timeout", 32'(dv), 1);
        wait_cnt = 0;
      end
      if (inval) gen++;
      prev_pc    = pc;
      prev_dv    = dv;
      prev_inval = inval;
      prev_rqv   = bus.memRequestValid;
      prev_rdy   = bus.memRequestReady;
      prev_rqa   = bus.memRequestAddress;
    end
    @(negedge clock);
    inval = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_buffer.md
# instruction_fetch_buffer

Instruction-side memory port sitting directly upstream of the fetch stage: it turns the fetch stage's program counter into memory read requests and returns `instructionData` / `instructionDataValid` to it. It holds a 2-entry address-tagged buffer and keeps one sequential prefetch (PC+4) in flight, so straight-line code does not pay full memory latency per instruction. It also flags misaligned and bus-error fetches as instruction faults.

## Interface
- `PREFETCH_ENABLE`, default 1: when 0, only demand misses are requested (no PC+4 prefetch).
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `instructionAddress`  in  32  fetch stage's registered program counter.
- `invalidateBuffer`  in  1  single-cycle pulse (trap redirect / fence.i); discards all buffered and in-flight data.
- `instructionDataValid`  out  1  buffer holds the word at `instructionAddress`, or the address is misaligned.
- `instructionData`  out  32  word for `instructionAddress`; 0 when faulting.
- `instructionFault`  out  1  qualifies `instructionDataValid`: misaligned address or bus error on that word.
- `memRequestValid`  out  1  read request.
- `memRequestAddress`  out  32  word-aligned read address.
- `memRequestReady`  in  1  memory accepts the request this cycle.
- `memResponseValid`  in  1  read data returned.
- `memResponseData`  in  32  read data.
- `memResponseError`  in  1  bus error on this response.

## Operation
- Buffer: entries 0/1, each with valid, 32-bit address, 32-bit data, error bit. A 1-bit replacement pointer selects which entry is overwritten.
- Hit: the entry is valid and its address equals `instructionAddress`.
- Outputs are combinational from registers and `instructionAddress`.
  - `instructionDataValid` = hit or misaligned.
  - `instructionData` = hit entry's data, else 0.
  - `instructionFault` = misaligned or hit entry's error bit.
  - If both entries match, entry 0 wins.
- Misaligned (`instructionAddress[1:0] != 0`): a fault is reported immediately and no request is issued for that address.
- Target selection (IDLE only):
  - If `instructionAddress` is aligned and misses, the target is `instructionAddress`.
  - Else, if PREFETCH_ENABLE, aligned, and `instructionAddress+4` (mod 2^32) misses, the target is `instructionAddress+4`.
  - Else no target.
- FSM:
  - IDLE: if a target exists, latch `memRequestAddress` = target and go to REQUEST. Otherwise stay.
  - REQUEST: `memRequestValid`=1. Address and valid are held stable until `memRequestReady`, even if `instructionAddress` changes. When `memRequestReady`=1, go to WAIT.
  - WAIT: on `memResponseValid`, write the entry (unless dropping) and go to IDLE.
- Response write:
  - Victim is the entry not hit by `instructionAddress` in that cycle. If neither or both hit, the victim is the replacement pointer's entry, and the pointer toggles.
  - Store address=`memRequestAddress`, data, error, valid=1.
  - A response whose address no longer matches the PC is still stored; this is how redirect squash works.
- `invalidateBuffer`:
  - Clears both valid bits at the next edge.
  - If asserted in REQUEST or WAIT, sets `dropPending`. The matching response is discarded (no write) and `dropPending` clears.
  - An invalidate in the same cycle as a response: that response is discarded.
  - The FSM never retracts an issued request.
- Memory contract: one response per accepted request, in order, no earlier than the cycle after acceptance. This block always accepts responses.

## Timing
- Reset values (asynchronous):
  - state IDLE, entry valids 0, pointer 0, `dropPending` 0.
  - `memRequestValid` 0, `memRequestAddress` 0.
  - `instructionDataValid`, `instructionFault` forced 0 and `instructionData` 0 while `reset` is high.
- Demand miss with memory ready and 1-cycle response: miss seen in cycle 0 (IDLE), request in cycle 1, response in cycle 2, `instructionDataValid` in cycle 3.
- Prefetch request for PC+4 starts the cycle after the demand word is written, from IDLE.
- Reset asserted mid-transaction: all state clears immediately. A response from the abandoned request may arrive after reset in IDLE; it is ignored, because responses are only consumed in WAIT.
- A stall by the fetch stage (PC held) keeps `instructionDataValid` asserted indefinitely. The buffer never evicts the hit entry.
- Address wrap: the prefetch of 0xFFFFFFFC targets 0x00000000.

## Test plan
- Reset, PC=0x0, memory ready, 1-cycle latency, returns 0x00000013 -> request 0x0 in cycle 1; `instructionDataValid`=1 with data 0x00000013 in cycle 3; next request is 0x4.
- Sequential run 0x0..0x10 with fetch advancing on valid -> every word is returned in address order, each with its PC+4 prefetched; no duplicate requests.
- Request 0x8 outstanding, PC redirects to 0x100 -> the 0x8 response is stored but `instructionDataValid`=0; the next request is 0x100; valid is asserted for 0x100 only.
- `invalidateBuffer` in WAIT for 0x20 -> response discarded, valids 0, re-request 0x20; `memRequestAddress` is held while `memRequestReady`=0 across 3 cycles.
- `memResponseError`=1 on 0x40 -> `instructionDataValid`=1, `instructionFault`=1, data 0. PC=0x42 -> fault in the same cycle, no request issued.
- Reset asserted mid-REQUEST -> `memRequestValid` drops immediately; a stray response in IDLE does not set any entry valid.
